// File: rtl/analinput_mc_if.sv
// Serial ADC pins plus the per-channel result bus of the analinput_mc front end.
interface analinput_mc_if #(
    parameter int unsigned NCHAN   = 2,
    parameter int unsigned OUTBITS = 10
);
    logic                       miso;
    logic                       mosi;
    logic                       sck;
    logic                       cs;
    logic [NCHAN*OUTBITS-1:0]   values;
    logic                       upd;
    logic [2:0]                 upd_ch;

    modport master (
        input  miso,
        output mosi, sck, cs, values, upd, upd_ch
    );

    modport slave (
        output miso,
        input  mosi, sck, cs, values, upd, upd_ch
    );
endinterface

// File: rtl/analinput_mc.sv
// Round-robin multi-channel SPI ADC poller with clamped per-channel result storage.
// Optional macro ANALINPUT_AVG_EN adds a first-order low-pass on every stored value.
module analinput_mc #(
    parameter int unsigned NCHAN     = 2,
    parameter int unsigned ADCBITS   = 12,
    parameter int unsigned OUTBITS   = 10,
    parameter int unsigned FRAMEBITS = 16,
    parameter int unsigned ADDRMSB   = 13,
    parameter int unsigned SCKDIV    = 2,
    parameter int unsigned GAPCYC    = 2,
    parameter int unsigned LOWLIM    = 48,
    parameter int unsigned HIGHLIM   = 432
) (
    input  logic              clk,
    input  logic              reset,
    analinput_mc_if.master    bus
);
    localparam int unsigned BitW = (FRAMEBITS > 1) ? $clog2(FRAMEBITS) : 1;
    localparam int unsigned DivW = $clog2(SCKDIV + 1);
    localparam int unsigned GapW = $clog2(GAPCYC + 1);

    localparam logic [1:0] StGap   = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [DivW-1:0]      div_cnt_q, div_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 last_q, last_d;
    logic [ADCBITS-1:0]   sr_q, sr_d;
    logic [2:0]           addr_q, addr_d;
    logic [2:0]           prev_q, prev_d;
    logic                 first_q, first_d;
    logic                 cs_q, cs_d;
    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic                 upd_q, upd_d;
    logic [2:0]           upd_ch_q, upd_ch_d;
    logic [OUTBITS-1:0]   vals_q [NCHAN];
    logic [OUTBITS-1:0]   vals_d [NCHAN];

    logic [FRAMEBITS-1:0]     cmd;
    logic [OUTBITS-1:0]       sample;
    logic [OUTBITS-1:0]       clamped;
    logic [OUTBITS-1:0]       new_val;
    logic [NCHAN*OUTBITS-1:0] vals_packed;

    always_comb begin
        cmd = '0;
        cmd[ADDRMSB -: 3] = addr_q;
    end

    always_comb begin
        sample = sr_q[ADCBITS-1 -: OUTBITS];
        if (sample < OUTBITS'(LOWLIM)) begin
            clamped = OUTBITS'(LOWLIM);
        end else if (sample > OUTBITS'(HIGHLIM)) begin
            clamped = OUTBITS'(HIGHLIM);
        end else begin
            clamped = sample;
        end
    end

`ifdef ANALINPUT_AVG_EN
    logic [OUTBITS-1:0]        old_val;
    logic signed [OUTBITS:0]   diff;
    logic signed [OUTBITS:0]   step;

    always_comb begin
        old_val = vals_q[0];
        for (int n = 0; n < NCHAN; n++) begin
            if (prev_q == 3'(n)) old_val = vals_q[n];
        end
        diff    = $signed({1'b0, clamped}) - $signed({1'b0, old_val});
        step    = diff >>> 2;
        // Sum stays inside [old, clamped], so dropping the sign bit is exact.
        new_val = old_val + step[OUTBITS-1:0];
    end
`else
    always_comb begin
        new_val = clamped;
    end
`endif

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        sr_d      = sr_q;
        addr_d    = addr_q;
        prev_d    = prev_q;
        first_d   = first_q;
        cs_d      = cs_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        upd_d     = 1'b0;
        upd_ch_d  = upd_ch_q;
        for (int n = 0; n < NCHAN; n++) vals_d[n] = vals_q[n];

        case (state_q)
            StGap: begin
                cs_d  = 1'b1;
                sck_d = 1'b1;
                if (gap_cnt_q == GapW'(GAPCYC - 1)) begin
                    state_d   = StShift;
                    gap_cnt_d = '0;
                    div_cnt_d = '0;
                    cs_d      = 1'b0;
                    sck_d     = 1'b0;
                    bit_cnt_d = BitW'(FRAMEBITS - 1);
                    last_d    = 1'b0;
                    mosi_d    = cmd[FRAMEBITS-1];
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (div_cnt_q == DivW'(SCKDIV - 1)) begin
                    div_cnt_d = '0;
                    if (!sck_q) begin
                        sck_d     = 1'b1;
                        sr_d      = {sr_q[ADCBITS-2:0], bus.miso};
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        if (bit_cnt_q == '0) last_d = 1'b1;
                    end else if (last_q) begin
                        // Final high half ends the frame; sck stays high.
                        state_d = StDone;
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        if (!first_q) begin
                            upd_d    = 1'b1;
                            upd_ch_d = prev_q;
                            for (int n = 0; n < NCHAN; n++) begin
                                if (prev_q == 3'(n)) vals_d[n] = new_val;
                            end
                        end
                    end else begin
                        sck_d  = 1'b0;
                        mosi_d = cmd[bit_cnt_q];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StDone: begin
                // The ADC answers one frame late, so remember who was just addressed.
                first_d   = 1'b0;
                prev_d    = addr_q;
                addr_d    = (addr_q == 3'(NCHAN - 1)) ? 3'd0 : addr_q + 3'd1;
                state_d   = StGap;
                gap_cnt_d = '0;
            end
            default: begin
                state_d   = StGap;
                gap_cnt_d = '0;
                cs_d      = 1'b1;
                sck_d     = 1'b1;
                mosi_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StGap;
            gap_cnt_q <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            sr_q      <= '0;
            addr_q    <= '0;
            prev_q    <= '0;
            first_q   <= 1'b1;
            cs_q      <= 1'b1;
            sck_q     <= 1'b1;
            mosi_q    <= 1'b0;
            upd_q     <= 1'b0;
            upd_ch_q  <= '0;
            for (int n = 0; n < NCHAN; n++) vals_q[n] <= OUTBITS'(LOWLIM);
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            sr_q      <= sr_d;
            addr_q    <= addr_d;
            prev_q    <= prev_d;
            first_q   <= first_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            upd_q     <= upd_d;
            upd_ch_q  <= upd_ch_d;
            for (int n = 0; n < NCHAN; n++) vals_q[n] <= vals_d[n];
        end
    end

    always_comb begin
        for (int n = 0; n < NCHAN; n++) vals_packed[n*OUTBITS +: OUTBITS] = vals_q[n];
    end

    assign bus.cs     = cs_q;
    assign bus.sck    = sck_q;
    assign bus.mosi   = mosi_q;
    assign bus.upd    = upd_q;
    assign bus.upd_ch = upd_ch_q;
    assign bus.values = vals_packed;
endmodule

// File: tb/tb_analinput_mc.sv
// Self-checking bench for analinput_mc: ADC pin model plus frame-level reference model.
module tb_analinput_mc;
    localparam int NCH    = 3;
    localparam int OB     = 10;
    localparam int AB     = 12;
    localparam int FB     = 16;
    localparam int LOW    = 48;
    localparam int HIGH   = 432;
    localparam int PERIOD = 2 + 2 * 2 * FB + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    analinput_mc_if #(.NCHAN(NCH), .OUTBITS(OB)) bus ();

    analinput_mc #(.NCHAN(NCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC pin model: loads a frame word on cs fall, shifts on sck fall, logs mosi on sck rise.
    logic          miso_m = 1'b0;
    logic [AB-1:0] adc_next = '0;
    logic [FB-1:0] word = '0;
    logic [FB-1:0] cmd_cap = '0;
    logic [FB-1:0] last_cmd = '0;
    int            rises = 0;
    int            last_rises = 0;
    logic          prev_cs = 1'bx;
    logic          prev_sck = 1'bx;
    assign bus.miso = miso_m;

    always @(bus.cs or bus.sck) begin
        if (bus.cs === 1'b0 && prev_cs !== 1'b0) begin
            word    = {4'($urandom), adc_next};
            rises   = 0;
            cmd_cap = '0;
            miso_m  = word[FB-1];
        end else if (bus.cs === 1'b0) begin
            if (bus.sck === 1'b1 && prev_sck === 1'b0) begin
                cmd_cap = {cmd_cap[FB-2:0], bus.mosi};
                rises++;
            end else if (bus.sck === 1'b0 && prev_sck === 1'b1 && rises > 0 && rises < FB) begin
                miso_m = word[FB-1-rises];
            end
        end
        if (bus.cs === 1'b1 && prev_cs === 1'b0) begin
            last_cmd   = cmd_cap;
            last_rises = rises;
            rises      = 0;
        end
        prev_cs  = bus.cs;
        prev_sck = bus.sck;
    end

    // Reference model state
    int exp_val [NCH];
    int m_addr;
    int m_prev;
    bit m_first;
    bit prev_valid;
    int last_fall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int adc);
        int v;
        v = adc >> (AB - OB);
        if (v < LOW) v = LOW;
        if (v > HIGH) v = HIGH;
        return v;
    endfunction

    function automatic int filt(input int old, input int c);
`ifdef ANALINPUT_AVG_EN
        return old + ((c - old) >>> 2);
`else
        return c;
`endif
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) exp_val[n] = LOW;
        m_addr     = 0;
        m_prev     = 0;
        m_first    = 1'b1;
        prev_valid = 1'b0;
    endtask

    task automatic check_values(input string tag);
        for (int n = 0; n < NCH; n++) chk(tag, 32'(bus.values[n*OB +: OB]), 32'(exp_val[n]));
    endtask

    task automatic wait_cs(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus.cs === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_frame(input logic [AB-1:0] adc);
        bit            ok;
        bit            exp_upd;
        int            exp_ch;
        logic [FB-1:0] exp_cmd;
        adc_next = adc;
        exp_cmd  = '0;
        exp_cmd  = FB'(m_addr) << 11;
        wait_cs(1'b0, ok);
        chk("cs_fall_timeout", 32'(ok), 32'd1);
        if (prev_valid) chk("frame_period", 32'(cyc - last_fall), 32'(PERIOD));
        last_fall = cyc;
        wait_cs(1'b1, ok);
        chk("cs_rise_timeout", 32'(ok), 32'd1);
        chk("sck_rises", 32'(last_rises), 32'(FB));
        chk("mosi_cmd", 32'(last_cmd), 32'(exp_cmd));
        chk("sck_idle_high", 32'(bus.sck), 32'd1);
        exp_upd = !m_first;
        exp_ch  = m_prev;
        if (exp_upd) exp_val[m_prev] = filt(exp_val[m_prev], clampv(int'(adc)));
        m_first    = 1'b0;
        m_prev     = m_addr;
        m_addr     = (m_addr + 1) % NCH;
        prev_valid = 1'b1;
        chk("upd", 32'(bus.upd), 32'(exp_upd));
        if (exp_upd) chk("upd_ch", 32'(bus.upd_ch), 32'(exp_ch));
        check_values("values");
        @(negedge clk);
        chk("upd_pulse_end", 32'(bus.upd), 32'd0);
    endtask

    initial begin
        bit ok;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(bus.cs), 32'd1);
        chk("rst_sck", 32'(bus.sck), 32'd1);
        chk("rst_mosi", 32'(bus.mosi), 32'd0);
        chk("rst_upd", 32'(bus.upd), 32'd0);
        chk("rst_upd_ch", 32'(bus.upd_ch), 32'd0);
        check_values("rst_values");
        reset = 1'b0;

        // Directed: mid-scale, bottom clamp, top clamp, in-range, then random codes.
        do_frame(12'h800);
        do_frame(12'h800);
        do_frame(12'h000);
        do_frame(12'hFFF);
        do_frame(12'h600);
        do_frame(12'h300);
        do_frame(12'hC00);
        do_frame(12'hC00);
        do_frame(12'hC00);
        for (int i = 0; i < 10; i++) do_frame(12'($urandom));

        // Reset while bit 7 of a frame is being shifted.
        adc_next = 12'($urandom);
        wait_cs(1'b0, ok);
        chk("mid_cs_fall_timeout", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (rises >= 8) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_bit_timeout", 32'(ok), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_cs", 32'(bus.cs), 32'd1);
        chk("mid_rst_sck", 32'(bus.sck), 32'd1);
        chk("mid_rst_mosi", 32'(bus.mosi), 32'd0);
        chk("mid_rst_upd", 32'(bus.upd), 32'd0);
        model_reset();
        check_values("mid_rst_values");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) do_frame(12'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
